// File: rtl/decoder_nto2n_seq.sv
// N-to-2^N registered one-hot decoder with a valid/ready direct-load port
// and an auto-scan mode that walks a single active output up or down.
module decoder_nto2n_seq #(
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned DWELL_W    = 8,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_valid,
  output logic                      sel_ready,
  input  logic [DWELL_W-1:0]        dwell,
  output logic [(1 << SEL_W)-1:0]   y,
  output logic                      y_valid,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      wrap
);

  localparam int unsigned      OUT_W   = 1 << SEL_W;
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(OUT_W - 1);
  localparam logic [OUT_W-1:0] Y_OFF   = {OUT_W{ACTIVE_LOW}};

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_DIRECT = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [OUT_W-1:0]     y_q, y_d;
  logic                 y_valid_q, y_valid_d;
  logic [SEL_W-1:0]     cur_sel_q, cur_sel_d;
  logic                 wrap_q, wrap_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 go_off;

  // Output polarity is folded in here so y can come straight off a flop.
  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] idx);
    logic [OUT_W-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r ^ Y_OFF;
  endfunction

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    cur_sel_d = cur_sel_q;
    cnt_d     = cnt_q;
    wrap_d    = 1'b0;
    go_off    = !en || (mode == MODE_OFF);
    sel_ready = en && (mode == MODE_DIRECT) && (state_q == ST_DIRECT);

    case (state_q)
      ST_IDLE: begin
        if (!go_off) begin
          if (mode == MODE_DIRECT) begin
            state_d = ST_DIRECT;
          end else begin
            state_d   = ST_SCAN;
            cur_sel_d = mode[0] ? SEL_MAX : '0;
            cnt_d     = dwell;
            y_d       = decode(cur_sel_d);
            y_valid_d = 1'b1;
          end
        end
      end

      ST_DIRECT: begin
        // A switch to scanning always detours through IDLE for one cycle.
        if (go_off || mode[1]) begin
          state_d   = ST_IDLE;
          y_d       = Y_OFF;
          y_valid_d = 1'b0;
          cnt_d     = '0;
        end else if (sel_valid) begin
          y_d       = decode(sel);
          cur_sel_d = sel;
          y_valid_d = 1'b1;
        end
      end

      ST_SCAN: begin
        if (go_off || (mode == MODE_DIRECT)) begin
          state_d   = ST_IDLE;
          y_d       = Y_OFF;
          y_valid_d = 1'b0;
          cnt_d     = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          // Direction is taken live, so an up/down flip lands on the next step.
          cnt_d = dwell;
          if (mode[0]) begin
            cur_sel_d = cur_sel_q - SEL_W'(1);
            wrap_d    = (cur_sel_q == '0);
          end else begin
            cur_sel_d = cur_sel_q + SEL_W'(1);
            wrap_d    = (cur_sel_q == SEL_MAX);
          end
          y_d = decode(cur_sel_d);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        y_d       = Y_OFF;
        y_valid_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      y_q       <= Y_OFF;
      y_valid_q <= 1'b0;
      cur_sel_q <= '0;
      wrap_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      cur_sel_q <= cur_sel_d;
      wrap_q    <= wrap_d;
      cnt_q     <= cnt_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign cur_sel = cur_sel_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Scoreboard bench for decoder_nto2n_seq: a 2-bit active-high instance driven
// through direct, scan and transition scenarios, plus a 3-bit active-low one.
module tb_decoder_nto2n_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [1:0] sel;
  logic       sel_valid;
  logic       sel_ready;
  logic [7:0] dwell;
  logic [3:0] y;
  logic       y_valid;
  logic [1:0] cur_sel;
  logic       wrap;

  logic       en8;
  logic [1:0] mode8;
  logic [2:0] sel8;
  logic       sel_valid8;
  logic       sel_ready8;
  logic [7:0] dwell8;
  logic [7:0] y8;
  logic       y_valid8;
  logic [2:0] cur_sel8;
  logic       wrap8;

  decoder_nto2n_seq #(.SEL_W(2), .DWELL_W(8), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .dwell(dwell),
    .y(y), .y_valid(y_valid), .cur_sel(cur_sel), .wrap(wrap)
  );

  decoder_nto2n_seq #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1'b1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .mode(mode8), .sel(sel8),
    .sel_valid(sel_valid8), .sel_ready(sel_ready8), .dwell(dwell8),
    .y(y8), .y_valid(y_valid8), .cur_sel(cur_sel8), .wrap(wrap8)
  );

  typedef struct packed {
    logic [3:0] y;
    logic       yv;
    logic [1:0] cs;
    logic       ccs;
    logic       w;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    checks   = 0;
  int    failures = 0;

  int dn_cs[6] = '{3, 2, 1, 0, 3, 2};
  int dn_w[6]  = '{0, 0, 0, 0, 1, 0};
  int up_cs[3] = '{3, 0, 1};
  int up_w[3]  = '{0, 1, 0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Queue the expected post-edge outputs, then advance one clock.
  task automatic cyc(input string nm, input logic [3:0] ey, input logic eyv,
                     input logic [1:0] ecs, input logic ccs, input logic ew);
    exp_t e;
    e.y = ey; e.yv = eyv; e.cs = ecs; e.ccs = ccs; e.w = ew;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: compare the registered outputs just after each edge with a pending expectation.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        check({n, ".y"},       32'(y),       32'(e.y));
        check({n, ".y_valid"}, 32'(y_valid), 32'(e.yv));
        check({n, ".wrap"},    32'(wrap),    32'(e.w));
        if (e.ccs) check({n, ".cur_sel"}, 32'(cur_sel), 32'(e.cs));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 2'b01; sel = 2'd0; sel_valid = 1'b0; dwell = 8'd0;
    en8 = 1'b1; mode8 = 2'b01; sel8 = 3'd0; sel_valid8 = 1'b0; dwell8 = 8'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst.y",         32'(y),         32'h0);
    check("rst.y_valid",   32'(y_valid),   32'h0);
    check("rst.cur_sel",   32'(cur_sel),   32'h0);
    check("rst.wrap",      32'(wrap),      32'h0);
    check("rst.sel_ready", 32'(sel_ready), 32'h0);
    check("rst.y8",        32'(y8),        32'hFF);
    rst_n = 1'b1;

    // Direct load, then hold with sel changing underneath.
    cyc("t1_enter", 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
    check("t1.sel_ready", 32'(sel_ready), 32'h1);
    sel = 2'd2; sel_valid = 1'b1;
    cyc("t1_load", 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);
    sel_valid = 1'b0; sel = 2'd1;
    cyc("t1_hold0", 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);
    cyc("t1_hold1", 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);

    // Scan up with dwell=2: each output held 3 cycles, wrap on 3->0.
    mode = 2'b10; dwell = 8'd2;
    cyc("t2_idle", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++)
      cyc("t2_scan", 4'(1 << ((i / 3) % 4)), 1'b1, 2'((i / 3) % 4), 1'b1, 1'(i == 12));

    // Scan down with dwell=0, then flip direction at cur_sel=2.
    mode = 2'b00;
    cyc("t3_off", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    mode = 2'b11; dwell = 8'd0;
    for (int i = 0; i < 6; i++)
      cyc("t3_dn", 4'(1 << dn_cs[i]), 1'b1, 2'(dn_cs[i]), 1'b1, 1'(dn_w[i]));
    mode = 2'b10;
    for (int i = 0; i < 3; i++)
      cyc("t3_flip", 4'(1 << up_cs[i]), 1'b1, 2'(up_cs[i]), 1'b1, 1'(up_w[i]));

    // Mode and enable transitions.
    mode = 2'b01;
    cyc("t4_to_idle",   4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc("t4_to_direct", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    check("t4.sel_ready_on", 32'(sel_ready), 32'h1);
    sel = 2'd1; sel_valid = 1'b1;
    cyc("t4_load", 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0);
    sel_valid = 1'b0; mode = 2'b10;
    cyc("t4_pass_idle",  4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc("t4_scan_entry", 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0);
    en = 1'b0;
    cyc("t4_disable", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    mode = 2'b01; sel = 2'd3; sel_valid = 1'b1;
    check("t4.sel_ready_off", 32'(sel_ready), 32'h0);
    cyc("t4_drop0", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc("t4_drop1", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    sel_valid = 1'b0; en = 1'b1;
    cyc("t4_reenter", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    check("t4.sel_ready_back", 32'(sel_ready), 32'h1);
    cyc("t4_no_queue", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a scan.
    mode = 2'b10; dwell = 8'd3;
    cyc("t5_idle", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++)
      cyc("t5_scan", 4'(1 << (i / 4)), 1'b1, 2'(i / 4), 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t5.y",       32'(y),       32'h0);
    check("t5.y_valid", 32'(y_valid), 32'h0);
    check("t5.cur_sel", 32'(cur_sel), 32'h0);
    check("t5.wrap",    32'(wrap),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Wide active-low instance.
    @(posedge clk);
    @(negedge clk);
    check("t6.y8_idle",     32'(y8),         32'hFF);
    check("t6.sel_ready8",  32'(sel_ready8), 32'h1);
    sel8 = 3'd5; sel_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sel_valid8 = 1'b0;
    check("t6.y8",          32'(y8),         32'hDF);
    check("t6.y_valid8",    32'(y_valid8),   32'h1);
    check("t6.cur_sel8",    32'(cur_sel8),   32'h5);
    #2 rst_n = 1'b0;
    #1;
    check("t6.y8_rst",       32'(y8),       32'hFF);
    check("t6.y_valid8_rst", 32'(y_valid8), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("sb.drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
